// File: rtl/scan_loader_pkg.sv
// Shared types and constants for the scan pattern-buffer loader.
package scan_loader_pkg;

    localparam int unsigned DEF_BUFFER_SIZE  = 32;
    localparam int unsigned DEF_BUFFER_WIDTH = 8;
    localparam int unsigned SADDR_W          = 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_e;

endpackage

// File: rtl/scan_loader_if.sv
// Host-side byte bus of the scan loader: start/addr, write stream, readback stream, status.
interface scan_loader_if #(
    parameter int unsigned BUFFER_WIDTH = scan_loader_pkg::DEF_BUFFER_WIDTH
) ();

    logic                                 start;
    logic [scan_loader_pkg::SADDR_W-1:0]  addr;
    logic [BUFFER_WIDTH-1:0]              wr_data;
    logic                                 wr_valid;
    logic                                 wr_ready;
    logic [BUFFER_WIDTH-1:0]              rd_data;
    logic                                 rd_valid;
    logic                                 busy;
    logic                                 done;

    modport master (
        output start, addr, wr_data, wr_valid,
        input  wr_ready, rd_data, rd_valid, busy, done
    );

    modport slave (
        input  start, addr, wr_data, wr_valid,
        output wr_ready, rd_data, rd_valid, busy, done
    );

endinterface

// File: rtl/scan_clkgen.sv
// Serial clock generator: counts CLK_DIV clk cycles per sclk phase and drives sclk high in SHIFT_HI.
module scan_clkgen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic hi_next,
    output logic sclk,
    output logic phase_last_c
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt_q;

    assign phase_last_c = active && (cnt_q == CW'(CLK_DIV - 1));

    // Phase counter restarts at every phase boundary so both halves last CLK_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else begin
            sclk <= hi_next;
            if (!active || phase_last_c) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/scan_loader.sv
// Loads BUFFER_SIZE bytes MSB-first into a selected serial pattern-buffer chain.
// Optional readback of the chain return data is enabled with SCAN_LOADER_READBACK_EN.
module scan_loader
    import scan_loader_pkg::*;
#(
    parameter int unsigned BUFFER_SIZE  = DEF_BUFFER_SIZE,
    parameter int unsigned BUFFER_WIDTH = DEF_BUFFER_WIDTH,
    parameter int unsigned CLK_DIV      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    scan_loader_if.slave       bus,
    output logic               sclk,
    output logic               sin,
    output logic               ssel,
    output logic [SADDR_W-1:0] saddr,
    input  logic               sout
);

    localparam int unsigned BCW = (BUFFER_SIZE > 1)  ? $clog2(BUFFER_SIZE)  : 1;
    localparam int unsigned BTW = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;

    state_e                  state_q, state_n;
    logic [BCW-1:0]          byte_q, byte_n;
    logic [BTW-1:0]          bit_q, bit_n;
    logic [BUFFER_WIDTH-1:0] sreg_q, sreg_n;
    logic [SADDR_W-1:0]      saddr_n;
    logic                    busy_q, busy_n;
    logic                    ssel_n;
    logic                    wr_ready_q, wr_ready_n;
    logic                    done_q, done_n;
    logic                    phase_last_c;

`ifdef SCAN_LOADER_READBACK_EN
    logic [BUFFER_WIDTH-1:0] rsh_q, rsh_n;
    logic [BUFFER_WIDTH-1:0] rd_data_q, rd_data_n;
    logic                    rd_valid_q, rd_valid_n;
`endif

    scan_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk          (clk),
        .rst_n        (rst_n),
        .active       ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)),
        .hi_next      (state_n == SHIFT_HI),
        .sclk         (sclk),
        .phase_last_c (phase_last_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_q;
        byte_n  = byte_q;
        bit_n   = bit_q;
        sreg_n  = sreg_q;
        saddr_n = saddr;
        busy_n  = busy_q;
        ssel_n  = ssel;
        done_n  = 1'b0;
`ifdef SCAN_LOADER_READBACK_EN
        rsh_n      = rsh_q;
        rd_data_n  = rd_data_q;
        rd_valid_n = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    saddr_n = bus.addr;
                    busy_n  = 1'b1;
                    ssel_n  = 1'b1;
                    byte_n  = '0;
                    bit_n   = '0;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (bus.wr_valid && wr_ready_q) begin
                    sreg_n  = bus.wr_data;
                    bit_n   = BTW'(BUFFER_WIDTH - 1);
                    state_n = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_last_c) begin
`ifdef SCAN_LOADER_READBACK_EN
                    // Return data is captured just before sclk rises.
                    rsh_n = {rsh_q[BUFFER_WIDTH-2:0], sout};
                    if (bit_q == '0) begin
                        rd_data_n  = {rsh_q[BUFFER_WIDTH-2:0], sout};
                        rd_valid_n = 1'b1;
                    end
`endif
                    state_n = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_last_c) begin
                    if (bit_q != '0) begin
                        bit_n   = bit_q - BTW'(1);
                        sreg_n  = {sreg_q[BUFFER_WIDTH-2:0], 1'b0};
                        state_n = SHIFT_LO;
                    end else if (byte_q != BCW'(BUFFER_SIZE - 1)) begin
                        byte_n  = byte_q + BCW'(1);
                        state_n = FETCH;
                    end else begin
                        busy_n  = 1'b0;
                        ssel_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                byte_n  = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // The first FETCH after start is a settle cycle; later fetches are ready at once.
        wr_ready_n = (state_n == FETCH) && (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            bit_q      <= '0;
            sreg_q     <= '0;
            saddr      <= '0;
            busy_q     <= 1'b0;
            ssel       <= 1'b0;
            wr_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            byte_q     <= byte_n;
            bit_q      <= bit_n;
            sreg_q     <= sreg_n;
            saddr      <= saddr_n;
            busy_q     <= busy_n;
            ssel       <= ssel_n;
            wr_ready_q <= wr_ready_n;
            done_q     <= done_n;
        end
    end

    assign sin          = sreg_q[BUFFER_WIDTH-1];
    assign bus.wr_ready = wr_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

`ifdef SCAN_LOADER_READBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsh_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rsh_q      <= rsh_n;
            rd_data_q  <= rd_data_n;
            rd_valid_q <= rd_valid_n;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`else
    logic unused_sout;
    assign unused_sout  = sout;
    assign bus.rd_data  = '0;
    assign bus.rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_scan_loader.sv
// Self-checking bench for scan_loader: table of transfers against a serial chain model and readback scoreboard.
module tb_scan_loader;
    import scan_loader_pkg::*;

    localparam int unsigned BS       = 32;
    localparam int unsigned BW       = 8;
    localparam int unsigned CD       = 2;
    localparam int unsigned NBITS    = BS * BW;
    localparam int          BASE_LAT = 1 + BS * (1 + 2 * CD * BW);

    typedef struct {
        int addr;
        int kind;
        int stall_byte;
        int stall_len;
        int glitch;
        int abort_byte;
        int exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scan_loader_if #(.BUFFER_WIDTH(BW)) bus ();
    logic sclk, sin, ssel, sout;
    logic [SADDR_W-1:0] saddr;

    scan_loader #(.BUFFER_SIZE(BS), .BUFFER_WIDTH(BW), .CLK_DIV(CD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .sclk  (sclk),
        .sin   (sin),
        .ssel  (ssel),
        .saddr (saddr),
        .sout  (sout)
    );

    // Pattern-buffer chain model: one NBITS-deep shift register per chain.
    logic [NBITS-1:0] chain [8];
    logic             sout_flip = 1'b0;
    initial for (int i = 0; i < 8; i++) chain[i] = '0;
    always @(posedge sclk) if (ssel) chain[saddr] <= {chain[saddr][NBITS-2:0], sin};
    assign sout = chain[saddr][NBITS-1] ^ sout_flip;
`ifndef SCAN_LOADER_READBACK_EN
    always @(negedge clk) sout_flip <= 1'($urandom_range(0, 1));
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Free-running monitors; the main sequence looks at deltas.
    int rises_tot = 0;
    int viol_tot  = 0;
    int rd_tot    = 0;
    int rd_bad    = 0;
    logic [SADDR_W-1:0] exp_addr = '0;
    bit   rd_chk = 1'b0;
    logic [BW-1:0] sbq [$];

    always @(posedge sclk) rises_tot <= rises_tot + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ssel && saddr !== exp_addr) viol_tot++;
            if (!ssel && sclk !== 1'b0) viol_tot++;
        end
        if (bus.rd_valid === 1'b1) begin
            rd_tot++;
            if (rd_chk) begin
                if (sbq.size() == 0) rd_bad++;
                else if (bus.rd_data !== sbq.pop_front()) rd_bad++;
            end
        end
    end

    logic [BW-1:0] last [8][BS];
    bit            clean [8];

    function automatic logic [BW-1:0] pat(input int kind, input int i);
        case (kind)
            0:       return BW'(i);
            1:       return 8'hA5;
            default: return BW'(i * 37 + 11);
        endcase
    endfunction

    task automatic run_xfer(input vec_t v);
        int hs, t0, lat, stall_cnt, stall_bad, busy_bad, ab_cnt;
        int r0, vl0, rd0, bad0;
        bit got_done, hsnow, aborted;
        hs = 0; lat = -1; stall_cnt = 0; stall_bad = 0; busy_bad = 0; ab_cnt = 0;
        got_done = 0; aborted = 0;
        exp_addr = SADDR_W'(v.addr);
        rd_chk   = clean[v.addr];
`ifdef SCAN_LOADER_READBACK_EN
        if (rd_chk) for (int i = 0; i < BS; i++) sbq.push_back(last[v.addr][i]);
`endif
        r0 = rises_tot; vl0 = viol_tot; rd0 = rd_tot; bad0 = rd_bad;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.addr = SADDR_W'(v.addr);
        bus.wr_valid = 1'b1; bus.wr_data = pat(v.kind, 0);
        @(posedge clk); #1;
        t0 = cyc;
        for (int k = 0; k < BASE_LAT + 200 && !got_done; k++) begin
            if (v.glitch != 0 && k == 100) begin
                bus.start = 1'b1; bus.addr = SADDR_W'(v.addr + 1);
            end else begin
                bus.start = 1'b0;
            end
            if (hs == v.stall_byte && bus.wr_ready && stall_cnt < v.stall_len) begin
                bus.wr_valid = 1'b0; stall_cnt++;
            end else begin
                bus.wr_valid = 1'b1;
            end
            bus.wr_data = pat(v.kind, hs);
            @(negedge clk);
            hsnow = bus.wr_valid && bus.wr_ready;
            if (!bus.wr_valid && bus.wr_ready && (sclk !== 1'b0 || ssel !== 1'b1)) stall_bad++;
            if (bus.done === 1'b1) begin
                got_done = 1; lat = cyc - t0;
                check("busy_at_done", 32'(bus.busy), 0);
                check("ssel_at_done", 32'(ssel), 0);
            end else if (bus.busy !== 1'b1) begin
                busy_bad++;
            end
            if (v.abort_byte >= 0 && hs > v.abort_byte) ab_cnt++;
            if (ab_cnt == 20) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_ssel", 32'(ssel), 0);
                check("rst_sclk", 32'(sclk), 0);
                check("rst_busy_done", {30'b0, bus.busy, bus.done}, 0);
                check("rst_ready_valid_sin", {29'b0, bus.wr_ready, bus.rd_valid, sin}, 0);
                check("rst_saddr", 32'(saddr), 0);
                check("rst_rd_data", 32'(bus.rd_data), 0);
                aborted = 1;
                break;
            end
            @(posedge clk); #1;
            if (hsnow) hs++;
        end
        bus.start = 1'b0; bus.wr_valid = 1'b0;
        if (aborted) begin
            check("abort_no_done", 32'(got_done), 0);
            check("abort_hs", 32'(hs), 32'(v.abort_byte + 1));
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            clean[v.addr] = 1'b0;
            rd_chk = 1'b0;
            sbq.delete();
            return;
        end
        check("latency", 32'(lat), 32'(v.exp_lat));
        check("sclk_rises", 32'(rises_tot - r0), NBITS);
        check("saddr_sclk_viol", 32'(viol_tot - vl0), 0);
        check("stall_hold", 32'(stall_bad), 0);
        check("stall_cycles", 32'(stall_cnt), 32'(v.stall_len));
        check("busy_window", 32'(busy_bad), 0);
        check("bytes_taken", 32'(hs), BS);
`ifdef SCAN_LOADER_READBACK_EN
        if (rd_chk) begin
            check("rd_count", 32'(rd_tot - rd0), BS);
            check("rd_mismatch", 32'(rd_bad - bad0), 0);
            check("sb_empty", 32'(sbq.size()), 0);
        end
`else
        check("rd_valid_never", 32'(rd_tot - rd0), 0);
        check("rd_data_zero", 32'(bus.rd_data), 0);
`endif
        @(negedge clk);
        check("done_one_cycle", {30'b0, bus.done, bus.busy}, 0);
        rd_chk = 1'b0;
        sbq.delete();
        for (int i = 0; i < BS; i++) last[v.addr][i] = pat(v.kind, i);
        clean[v.addr] = 1'b1;
    endtask

    vec_t tbl [5];
    vec_t hv;

    initial begin
        bus.start = 1'b0; bus.addr = '0; bus.wr_data = '0; bus.wr_valid = 1'b0;
        for (int a = 0; a < 8; a++) begin
            clean[a] = 1'b1;
            for (int i = 0; i < BS; i++) last[a][i] = '0;
        end
        //        addr kind stall_b len glitch abort  latency
        tbl[0] = '{5, 0, -1, 0,  0, -1, BASE_LAT};
        tbl[1] = '{1, 1, -1, 0,  0, -1, BASE_LAT};
        tbl[2] = '{1, 1, -1, 0,  0, -1, BASE_LAT};
        tbl[3] = '{5, 2,  4, 10, 0, -1, BASE_LAT + 10};
        tbl[4] = '{5, 0, -1, 0,  1, -1, BASE_LAT};

        #12;
        check("reset_ssel_sclk", {30'b0, ssel, sclk}, 0);
        check("reset_status", {29'b0, bus.busy, bus.done, bus.wr_ready}, 0);
        check("reset_saddr_sin", {28'b0, saddr, sin}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {29'b0, bus.busy, ssel, bus.rd_valid}, 0);

        for (int t = 0; t < 5; t++) run_xfer(tbl[t]);

        // Reset in the middle of byte 12, then a fresh full transfer to the same chain.
        hv = '{3, 2, -1, 0, 0, 12, BASE_LAT};
        run_xfer(hv);
        hv = '{3, 0, -1, 0, 0, -1, BASE_LAT};
        run_xfer(hv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/scan_loader.md
SCAN_LOADER -- requirements
Module: scan_loader

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 32, meaning bytes per pattern buffer chain.
REQ-002 SHALL have parameter BUFFER_WIDTH, default 8, meaning bits per byte.
REQ-003 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per sclk phase (1..15).
REQ-004 clk  input  1  system clock; all logic on rising edge; one clock only.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  begin transfer to buffer addr; sampled in IDLE only.
REQ-007 addr  input  3  target buffer index, latched at start.
REQ-008 wr_data  input  BUFFER_WIDTH  byte to shift in.
REQ-009 wr_valid  input  1  wr_data valid.
REQ-010 wr_ready  output  1  byte accepted when wr_valid && wr_ready.
REQ-011 rd_data  output  BUFFER_WIDTH  byte shifted out of chain.
REQ-012 rd_valid  output  1  one-cycle strobe, rd_data valid; no backpressure.
REQ-013 busy  output  1  high from start accept until done.
REQ-014 done  output  1  one-cycle pulse at transfer end.
REQ-015 sclk, sin, ssel  output  1 each  serial chain clock, data, select to pattern buffers.
REQ-016 saddr  output  3  chain select, equals latched addr.
REQ-017 sout  input  1  serial chain return data.

Function
REQ-018 States SHALL be IDLE, FETCH, SHIFT_LO, SHIFT_HI, DONE.
REQ-019 IDLE: start=1 -> latch addr, busy=1, ssel=1, go FETCH next cycle; start ignored in all other states.
REQ-020 FETCH: wr_ready=1 only here; on handshake load shift register, bit counter=BUFFER_WIDTH-1, go SHIFT_LO; wr_valid low -> stay, sclk held low, ssel held high (stall).
REQ-021 SHIFT_LO: sclk=0, sin=current bit MSB-first, held CLK_DIV cycles, then SHIFT_HI.
REQ-022 SHIFT_HI: sclk=1 for CLK_DIV cycles; sin stable throughout; sout sampled on last clk of SHIFT_LO (before sclk rises).
REQ-023 After SHIFT_HI: bits remain -> SHIFT_LO; byte done and bytes remain -> FETCH; last bit of byte BUFFER_SIZE-1 -> DONE.
REQ-024 DONE: done=1, ssel=0, busy=0, sclk=0 for one cycle, then IDLE.
REQ-025 Byte counter SHALL wrap-free count 0..BUFFER_SIZE-1, width clog2(BUFFER_SIZE).
REQ-026 Readback: 8 sampled sout bits assembled MSB-first; rd_valid pulses the cycle after 8th sample.
REQ-027 Latency with wr_valid held high: done asserted exactly 1+BUFFER_SIZE*(1+2*CLK_DIV*BUFFER_WIDTH) cycles after start sampled (1057 at defaults).
REQ-028 saddr SHALL not change while ssel=1; sclk SHALL never toggle while ssel=0.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, sclk=0, sin=0, ssel=0, saddr=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, counters 0.
REQ-030 Reset mid-transfer SHALL abort with no done pulse; next start begins full transfer.

Configuration
REQ-031 SCAN_LOADER_READBACK_EN defined: sout sampling and rd_data/rd_valid per REQ-026.
REQ-032 SCAN_LOADER_READBACK_EN undefined: sout ignored, rd_data=0, rd_valid=0 constant; load timing unchanged.

Structure
REQ-033 Shared package SHALL hold state enum type, default BUFFER_SIZE/BUFFER_WIDTH constants, saddr width constant.
REQ-034 Sub-module scan_clkgen SHALL own CLK_DIV phase counter and sclk generation; FSM in scan_loader.

Verification
REQ-035 start, addr=5, bytes 0x00..0x1F with wr_valid high -> saddr=5 throughout, 256 sclk rises, done at cycle 1057.
REQ-036 Two back-to-back loads of 0xA5 pattern into same chain model -> second pass rd_data returns 32x 0xA5 (readback enabled).
REQ-037 wr_valid dropped 10 cycles before byte 4 -> sclk held low, ssel high, no extra edges; done delayed by exactly stall length.
REQ-038 rst_n asserted mid byte 12 -> ssel=0, sclk=0 same cycle, no done; fresh transfer completes normally.
REQ-039 start pulsed while busy -> ignored, transfer count and done timing unchanged.
REQ-040 Build without SCAN_LOADER_READBACK_EN, toggle sout -> rd_valid never asserts, load identical to REQ-035.
